// File: rtl/datareg_pkg.sv
// datareg_pkg: shared width, FSM encoding and requester index type for datareg_arbiter
package datareg_pkg;
  localparam int DATA_WIDTH = 16;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  typedef logic [1:0] idx_t;
  function automatic idx_t idx_inc(idx_t i, int n);
    return (i == idx_t'(n - 1)) ? '0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/datareg_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search of req starting at ptr, wrapping at NREQ
// Ports: req (request vector), ptr (search start), win (winner index), found (any request)
module rr_picker
  import datareg_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output idx_t            win,
  output logic            found
);
  logic [3:0] r4;
  always_comb begin
    r4 = '0;
    r4[NREQ-1:0] = req;
    win = '0;
    found = 1'b0;
    // scan farthest-first so the nearest hit to ptr is the last one written
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j -= NREQ;
      if (r4[j[1:0]]) begin
        win = j[1:0];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/datareg_arbiter.sv
// datareg_arbiter: round-robin write arbiter owning the shadow value driven into DataReg16b.data_in
// Ports: clock, reset_n (async active-low), req/lock/wdata per requester in;
//        gnt (registered one-hot), reg_data (to DataReg16b.data_in), owner, busy, lock_abort out.
// Optional locked bursts enabled by defining DATAREG_ARB_LOCK_EN.
module datareg_arbiter
  import datareg_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = DATA_WIDTH,
  parameter int MAX_LOCK = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      reg_data,
  output logic [1:0]            owner,
  output logic                  busy,
  output logic                  lock_abort
);
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] data_q;
  idx_t             owner_q, ptr_q, win;
  logic             found;
  rr_picker #(.NREQ(NREQ)) u_pick (.req(req), .ptr(ptr_q), .win(win), .found(found));
  assign gnt = gnt_q;
  assign reg_data = data_q;
  assign owner = owner_q;
`ifdef DATAREG_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          abort_q;
  logic          hold;
  assign hold = req[owner_q] && lock[owner_q];
  assign busy = state_q == LOCKED;
  assign lock_abort = abort_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      abort_q <= 1'b0;
      gnt_q <= '0;
      data_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
    end else begin
      abort_q <= 1'b0;
      if (state_q == IDLE) begin
        gnt_q <= found ? (NREQ'(1) << win) : '0;
        if (found) begin
          data_q <= wdata[win*WIDTH +: WIDTH];
          owner_q <= win;
          ptr_q <= idx_inc(win, NREQ);
        end
        if (found && lock[win]) begin
          state_q <= LOCKED;
          cnt_q <= CW'(1);
        end
      end else if (hold && cnt_q < CW'(MAX_LOCK)) begin
        gnt_q <= NREQ'(1) << owner_q;
        data_q <= wdata[owner_q*WIDTH +: WIDTH];
        cnt_q <= cnt_q + CW'(1);
      end else begin
        // ptr already points past owner since lock entry, so release needs no pointer update
        state_q <= IDLE;
        gnt_q <= '0;
        cnt_q <= '0;
        abort_q <= hold;
      end
    end
`else
  logic unused_lock;
  assign unused_lock = ^lock ^ (MAX_LOCK > 0);
  assign busy = 1'b0;
  assign lock_abort = 1'b0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      gnt_q <= '0;
      data_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= found ? (NREQ'(1) << win) : '0;
      if (found) begin
        data_q <= wdata[win*WIDTH +: WIDTH];
        owner_q <= win;
        ptr_q <= idx_inc(win, NREQ);
      end
    end
`endif
endmodule

// File: tb/tb_datareg_arbiter.sv
// tb_datareg_arbiter: scoreboard bench for datareg_arbiter with a DataReg16b stand-in
module tb_datareg_arbiter;
  typedef struct packed {
    logic [3:0]  g;
    logic [15:0] d;
    logic [1:0]  o;
    logic        b;
    logic        a;
    logic [15:0] dr;
  } exp_t;
`ifdef DATAREG_ARB_LOCK_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] req, lock, gnt;
  logic [63:0] wdata;
  logic [15:0] reg_data, dr_q, last_d;
  logic [1:0] owner;
  logic busy, lock_abort;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

  datareg_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .reg_data(reg_data), .owner(owner), .busy(busy), .lock_abort(lock_abort)
  );

  always #5 clock = ~clock;
  always @(posedge clock) dr_q <= reg_data;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [63:0] w,
                      input logic [3:0] g, input logic [15:0] d, input logic [1:0] o,
                      input logic b, input logic a);
    @(negedge clock);
    req = r;
    lock = l;
    wdata = w;
    q.push_back('{g, d, o, b, a, last_d});
    last_d = d;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out{gnt,data,owner,busy,abort,dreg}",
            40'({gnt, reg_data, owner, busy, lock_abort, dr_q}), 40'(e));
      end
    end
  end

  initial begin
    logic [63:0] rr;
    rr = {16'd4, 16'd3, 16'd2, 16'd1};
    reset_n = 1'b0;
    req = 4'b1111;
    lock = 4'b1111;
    wdata = 64'hDEAD_BEEF_1234_5678;
    last_d = '0;
    #1;
    chk("reset gnt", 40'(gnt), 40'd0);
    chk("reset data", 40'(reg_data), 40'd0);
    chk("reset owner", 40'(owner), 40'd0);
    chk("reset busy/abort", 40'({busy, lock_abort}), 40'd0);
    @(posedge clock);
    @(posedge clock);
    #1 chk("reset dreg", 40'(dr_q), 40'd0);
    @(negedge clock);
    reset_n = 1'b1;
    req = '0;
    lock = '0;
    step(4'b0010, 4'b0, {16'd0, 16'd0, 16'd27, 16'd0}, 4'b0010, 16'd27, 2'd1, 1'b0, 1'b0);
    step(4'b0000, 4'b0, 64'd0, 4'b0000, 16'd27, 2'd1, 1'b0, 1'b0);
    step(4'b0000, 4'b0, 64'd0, 4'b0000, 16'd27, 2'd1, 1'b0, 1'b0);
    step(4'b1000, 4'b0, {16'd9, 48'd0}, 4'b1000, 16'd9, 2'd3, 1'b0, 1'b0);
    step(4'b1111, 4'b0, rr, 4'b0001, 16'd1, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b0, rr, 4'b0010, 16'd2, 2'd1, 1'b0, 1'b0);
    step(4'b1111, 4'b0, rr, 4'b0100, 16'd3, 2'd2, 1'b0, 1'b0);
    step(4'b1111, 4'b0, rr, 4'b1000, 16'd4, 2'd3, 1'b0, 1'b0);
    step(4'b1111, 4'b0, rr, 4'b0001, 16'd1, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0, rr, 4'b0000, 16'd1, 2'd0, 1'b0, 1'b0);
`ifdef DATAREG_ARB_LOCK_EN
    step(4'b0101, 4'b0100, {16'd0, 16'hFFFF, 16'd0, 16'h00AA}, 4'b0100, 16'hFFFF, 2'd2, 1'b1, 1'b0);
    step(4'b0101, 4'b0100, {16'd0, 16'h1234, 16'd0, 16'h00AA}, 4'b0100, 16'h1234, 2'd2, 1'b1, 1'b0);
    step(4'b0101, 4'b0100, {16'd0, 16'h0001, 16'd0, 16'h00AA}, 4'b0100, 16'h0001, 2'd2, 1'b1, 1'b0);
    step(4'b0101, 4'b0000, {16'd0, 16'h0001, 16'd0, 16'h00AA}, 4'b0000, 16'h0001, 2'd2, 1'b0, 1'b0);
    step(4'b0101, 4'b0000, {16'd0, 16'h0001, 16'd0, 16'h00AA}, 4'b0001, 16'h00AA, 2'd0, 1'b0, 1'b0);
`else
    step(4'b0101, 4'b0100, {16'd0, 16'hFFFF, 16'd0, 16'h00AA}, 4'b0100, 16'hFFFF, 2'd2, 1'b0, 1'b0);
    step(4'b0101, 4'b0100, {16'd0, 16'h1234, 16'd0, 16'h00AA}, 4'b0001, 16'h00AA, 2'd0, 1'b0, 1'b0);
    step(4'b0101, 4'b0100, {16'd0, 16'h0001, 16'd0, 16'h00AA}, 4'b0100, 16'h0001, 2'd2, 1'b0, 1'b0);
    step(4'b0101, 4'b0000, {16'd0, 16'h0001, 16'd0, 16'h00AA}, 4'b0001, 16'h00AA, 2'd0, 1'b0, 1'b0);
    step(4'b0101, 4'b0000, {16'd0, 16'h0001, 16'd0, 16'h00AA}, 4'b0100, 16'h0001, 2'd2, 1'b0, 1'b0);
`endif
    step(4'b0010, 4'b0010, {32'd0, 16'h0011, 16'd0}, 4'b0010, 16'h0011, 2'd1, LK, 1'b0);
    step(4'b0010, 4'b0010, {32'd0, 16'h0022, 16'd0}, 4'b0010, 16'h0022, 2'd1, LK, 1'b0);
    step(4'b0010, 4'b0010, {32'd0, 16'h0033, 16'd0}, 4'b0010, 16'h0033, 2'd1, LK, 1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("midreset gnt", 40'(gnt), 40'd0);
    chk("midreset data", 40'(reg_data), 40'd0);
    chk("midreset owner", 40'(owner), 40'd0);
    chk("midreset busy/abort", 40'({busy, lock_abort}), 40'd0);
    @(posedge clock);
    #1 chk("midreset dreg", 40'(dr_q), 40'd0);
    @(negedge clock);
    reset_n = 1'b1;
    req = '0;
    lock = '0;
    last_d = '0;
    step(4'b1001, 4'b0, {16'h000D, 32'd0, 16'h000A}, 4'b0001, 16'h000A, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic [63:0] w;
      w = {32'd0, 16'(k), 16'h0F0F};
`ifdef DATAREG_ARB_LOCK_EN
      if (k <= 8) step(4'b0011, 4'b0010, w, 4'b0010, 16'(k), 2'd1, 1'b1, 1'b0);
      else if (k == 9) step(4'b0011, 4'b0010, w, 4'b0000, 16'd8, 2'd1, 1'b0, 1'b1);
      else step(4'b0011, 4'b0010, w, 4'b0001, 16'h0F0F, 2'd0, 1'b0, 1'b0);
`else
      if (k % 2 == 1) step(4'b0011, 4'b0010, w, 4'b0010, 16'(k), 2'd1, 1'b0, 1'b0);
      else step(4'b0011, 4'b0010, w, 4'b0001, 16'h0F0F, 2'd0, 1'b0, 1'b0);
`endif
    end
    step(4'b0000, 4'b0000, 64'd0, 4'b0000, 16'h0F0F, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    #2;
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d pending expected %0d", q.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
